// File: rtl/filter_receiver.sv
// rtl/filter_receiver.sv - first-word-fall-through receive buffer with issuer backpressure and done tracking.
// Optional index sequence checker enabled by defining FILTER_RECEIVER_SEQ_CHECK_EN.
module filter_receiver #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              filter_en,
  input  logic [DATA_W-1:0] filter_data,
  input  logic [12:0]       filter_issue_counter,
  input  logic [12:0]       filter_length,
  output logic              filter_block,
  output logic [DATA_W-1:0] out_data,
  output logic [12:0]       out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              overflow_error,
  output logic              seq_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LEVEL  = CW'(DEPTH);
  localparam logic [CW-1:0] BLOCK_LEVEL = CW'(DEPTH - 1);

  logic [DATA_W+12:0] mem [DEPTH];
  logic [AW-1:0]      head;
  logic [AW-1:0]      tail;
  logic [CW-1:0]      count;
  logic [12:0]        delivered;
  logic               full;
  logic               pop;
  logic               push;

  assign full      = (count == FULL_LEVEL);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop frees the slot on the same edge, so a full buffer still takes a word.
  assign push      = !rst && filter_en && (!full || pop);
  // Block one entry early: the issuer's enable lags block by one cycle.
  assign filter_block = (count >= BLOCK_LEVEL);
  assign {out_index, out_data} = mem[head];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= {filter_issue_counter, filter_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      delivered      <= '0;
      done           <= 1'b0;
      overflow_error <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + AW'(1);
      end
      if (pop) begin
        head      <= head + AW'(1);
        delivered <= delivered + 13'd1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (filter_en && !push) begin
        overflow_error <= 1'b1;
      end
      if (delivered == filter_length && count == '0) begin
        done <= 1'b1;
      end
    end
  end

`ifdef FILTER_RECEIVER_SEQ_CHECK_EN
  logic [12:0] expected_index;

  // Resynchronise to the received index so one gap flags once, not forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      expected_index <= '0;
      seq_error      <= 1'b0;
    end else if (push) begin
      if (filter_issue_counter != expected_index) begin
        seq_error <= 1'b1;
      end
      expected_index <= filter_issue_counter + 13'd1;
    end
  end
`else
  assign seq_error = 1'b0;
`endif

endmodule

// File: tb/tb_filter_receiver.sv
// tb/tb_filter_receiver.sv - scoreboard bench for filter_receiver with a queue-level reference model.
module tb_filter_receiver;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 18;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              filter_en = 1'b0;
  logic [DATA_W-1:0] filter_data = '0;
  logic [12:0]       filter_issue_counter = '0;
  logic [12:0]       filter_length = '0;
  logic              filter_block;
  logic [DATA_W-1:0] out_data;
  logic [12:0]       out_index;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              done;
  logic              overflow_error;
  logic              seq_error;

  filter_receiver #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .filter_en(filter_en), .filter_data(filter_data),
    .filter_issue_counter(filter_issue_counter), .filter_length(filter_length),
    .filter_block(filter_block), .out_data(out_data), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .done(done),
    .overflow_error(overflow_error), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0]       idx;
    logic [DATA_W-1:0] data;
  } word_t;

  word_t       sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          mcount = 0;
  int          deliv = 0;
  bit          done_m = 0;
  bit          ovf_m = 0;
  bit          seq_m = 0;
  bit          chk = 0;
  bit          blk_last = 0;
  logic [12:0] exp_idx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: compare outputs against the model, drive inputs, advance the model.
  task automatic cycle(input bit en, input logic [12:0] idx, input bit rdy, input bit r);
    bit pop;
    bit acc;
    word_t w;
    if (chk) begin
      check("out_valid", 32'(out_valid), 32'(mcount != 0));
      check("filter_block", 32'(filter_block), 32'(mcount >= DEPTH - 1));
      check("done", 32'(done), 32'(done_m));
      check("overflow_error", 32'(overflow_error), 32'(ovf_m));
      check("seq_error", 32'(seq_error), 32'(seq_m));
    end
    blk_last = (mcount >= DEPTH - 1);
    rst = r;
    filter_en = en;
    out_ready = rdy;
    filter_issue_counter = idx;
    filter_data = DATA_W'($urandom);
    if (r) begin
      sb.delete();
      mcount = 0; deliv = 0; done_m = 0; ovf_m = 0; seq_m = 0; exp_idx = '0;
    end else begin
      pop = (mcount != 0) && rdy;
      acc = en && (mcount < DEPTH || pop);
      if (deliv == int'(filter_length) && mcount == 0) done_m = 1;
      if (en && !acc) ovf_m = 1;
      if (acc) begin
        w.idx = idx;
        w.data = filter_data;
        sb.push_back(w);
`ifdef FILTER_RECEIVER_SEQ_CHECK_EN
        if (idx != exp_idx) seq_m = 1;
        exp_idx = idx + 13'd1;
`endif
      end
      mcount = mcount + int'(acc) - int'(pop);
      if (pop) deliv = (deliv + 1) % 8192;
    end
    @(posedge clk);
    @(negedge clk);
    if (r) chk = 1;
  endtask

  task automatic do_reset(input logic [12:0] len);
    filter_length = len;
    cycle(1'b1, 13'd0, 1'b1, 1'b1);
  endtask

  // Monitor: pops the scoreboard on every completed output handshake.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(out_index), 32'h1fff_ffff);
        end else begin
          e = sb.pop_front();
          check("out_index", 32'(out_index), 32'(e.idx));
          check("out_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    logic [12:0] idx;
    bit en;
    @(negedge clk);
    do_reset(13'd5);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_block", 32'(filter_block), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // Back-to-back transfer of five words with free-flowing output.
    for (int i = 0; i < 5; i++) cycle(1'b1, 13'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 13'd0, 1'b1, 1'b0);
    check("done_len5", 32'(done), 32'd1);

    // Issuer honours block with a one-cycle lag; output stalled, then drained.
    do_reset(13'd8);
    idx = '0;
    for (int i = 0; i < 12; i++) begin
      en = !blk_last;
      cycle(en, idx, 1'b0, 1'b0);
      if (en) idx++;
    end
    check("fill_no_overflow", 32'(overflow_error), 32'd0);
    for (int i = 0; i < 11; i++) cycle(1'b0, 13'd0, 1'b1, 1'b0);

    // Full buffer: push with pop accepted, push without pop dropped.
    do_reset(13'd100);
    for (int i = 0; i < 8; i++) cycle(1'b1, 13'(i), 1'b0, 1'b0);
    cycle(1'b1, 13'd8, 1'b1, 1'b0);
    cycle(1'b1, 13'd9, 1'b0, 1'b0);
    check("overflow_set", 32'(overflow_error), 32'd1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 13'd0, 1'b1, 1'b0);

    // Reset mid-transfer discards buffered words; fresh three-word transfer follows.
    do_reset(13'd100);
    for (int i = 0; i < 4; i++) cycle(1'b1, 13'(i), 1'b0, 1'b0);
    do_reset(13'd3);
    check("midreset_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 13'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 13'd0, 1'b1, 1'b0);

    // Zero-length transfer completes immediately.
    do_reset(13'd0);
    cycle(1'b0, 13'd0, 1'b0, 1'b0);
    check("done_len0", 32'(done), 32'd1);

    // Index gap 0,1,3.
    do_reset(13'd3);
    cycle(1'b1, 13'd0, 1'b1, 1'b0);
    cycle(1'b1, 13'd1, 1'b1, 1'b0);
    cycle(1'b1, 13'd3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 13'd0, 1'b1, 1'b0);

    // Randomised traffic, ignoring block so overflow and drops also occur.
    for (int run = 0; run < 4; run++) begin
      do_reset(13'($urandom_range(1, 40)));
      idx = '0;
      for (int i = 0; i < 250; i++) begin
        en = ($urandom_range(0, 9) < 6);
        if (en && $urandom_range(0, 31) == 0) idx = idx + 13'd1;
        cycle(en, idx, ($urandom_range(0, 9) < 6), 1'b0);
        if (en) idx++;
      end
      for (int i = 0; i < 12; i++) cycle(1'b0, 13'd0, 1'b1, 1'b0);
      check("drained", 32'(sb.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
